// File: rtl/render_pkg.sv
// Shared constants and pipeline types for the render fetch scheduler.
// Field geometry, memory-select encodings and character IDs live here.
package render_pkg;

  localparam int NUM_CHARS   = 5;
  localparam int SPRITE_SIZE = 16;

  localparam logic [9:0] FIELD_X0   = 10'd208;
  localparam logic [9:0] FIELD_Y0   = 10'd96;
  localparam logic [9:0] FIELD_COLS = 10'd28;
  localparam logic [9:0] FIELD_ROWS = 10'd36;
  localparam logic [9:0] FIELD_W    = FIELD_COLS * 10'd8;
  localparam logic [9:0] FIELD_H    = FIELD_ROWS * 10'd8;

  typedef enum logic [1:0] {
    SEL_BLANK = 2'b00,
    SEL_TILE  = 2'b01,
    SEL_CHAR  = 2'b11
  } mem_sel_e;

  typedef enum logic [3:0] {
    CHAR_PACMAN = 4'd0,
    CHAR_BLINKY = 4'd1,
    CHAR_PINKY  = 4'd2,
    CHAR_INKY   = 4'd3,
    CHAR_CLYDE  = 4'd4
  } char_id_e;

  // Stage 1: playfield-relative coordinates of the incoming pixel.
  typedef struct packed {
    logic       valid;
    logic       in_field;
    logic [9:0] px;
    logic [9:0] py;
  } s1_t;

  // Stage 2: resolved sprite hit plus the in-tile position for the tile path.
  typedef struct packed {
    logic       valid;
    logic       in_field;
    logic       hit;
    logic [3:0] which;
    logic [3:0] dx;
    logic [3:0] dy;
    logic [2:0] tx;
    logic [2:0] ty;
  } s2_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] sel;
    logic [7:0] map;
    logic [1:0] item;
    logic [3:0] which;
    logic [5:0] toff;
    logic [7:0] coff;
  } out_t;

endpackage

// File: rtl/sprite_hit_unit.sv
// Combinational 16x16 box test of one character against a playfield pixel.
// RENDER_TUNNEL_WRAP_EN makes the horizontal distance wrap modulo the field width.
module sprite_hit_unit
  import render_pkg::*;
(
  input  logic [9:0] i_px,
  input  logic [9:0] i_py,
  input  logic [7:0] i_x,
  input  logic [8:0] i_y,
  input  logic       i_en,
  output logic       o_hit,
  output logic [3:0] o_dx,
  output logic [3:0] o_dy
);

  logic [10:0] dxw;
  logic [10:0] dyw;

  // Differences are one bit wider than the operands, so a pixel left of or
  // above the sprite wraps to a large unsigned value and fails the < 16 test.
  always_comb begin
`ifdef RENDER_TUNNEL_WRAP_EN
    dxw = {1'b0, i_px} + 11'(FIELD_W) - {3'b000, i_x};
    if (dxw >= 11'(FIELD_W)) dxw = dxw - 11'(FIELD_W);
`else
    dxw = {1'b0, i_px} - {3'b000, i_x};
`endif
    dyw   = {1'b0, i_py} - {2'b00, i_y};
    o_hit = i_en && (dxw < 11'(SPRITE_SIZE)) && (dyw < 11'(SPRITE_SIZE));
    o_dx  = dxw[3:0];
    o_dy  = dyw[3:0];
  end

endmodule

// File: rtl/render_fetch_scheduler.sv
// Three-stage pixel-to-address front end feeding the tile/sprite memory controller.
// Build option RENDER_TUNNEL_WRAP_EN (see sprite_hit_unit) wraps sprites across the tunnel.
module render_fetch_scheduler
  import render_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_valid,
  input  logic [9:0]  i_pix_x,
  input  logic [9:0]  i_pix_y,
  input  logic        i_frame_start,
  input  logic [39:0] i_char_x,
  input  logic [44:0] i_char_y,
  input  logic [4:0]  i_char_en,
  output logic [9:0]  o_board_addr,
  input  logic [7:0]  i_board_tile,
  input  logic [1:0]  i_board_item,
  output logic        o_valid,
  output logic [1:0]  o_mem_select,
  output logic [7:0]  o_address_map,
  output logic [1:0]  o_address_item,
  output logic [3:0]  o_which_char,
  output logic [5:0]  o_tile_offset,
  output logic [7:0]  o_char_offset
);

  logic [39:0] shx_q, shx_d;
  logic [44:0] shy_q, shy_d;
  logic [4:0]  shen_q, shen_d;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  out_t out_q, out_d;

  logic [NUM_CHARS-1:0]      hit;
  logic [NUM_CHARS-1:0][3:0] hit_dx;
  logic [NUM_CHARS-1:0][3:0] hit_dy;
  logic                      any_hit;
  char_id_e                  win_id;
  logic [3:0]                win_dx;
  logic [3:0]                win_dy;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    shx_d  = shx_q;
    shy_d  = shy_q;
    shen_d = shen_q;
    if (i_frame_start) begin
      shx_d  = i_char_x;
      shy_d  = i_char_y;
      shen_d = i_char_en;
    end

    s1_d       = '0;
    s1_d.valid = i_pix_valid;
    if (i_pix_valid) begin
      s1_d.px       = i_pix_x - FIELD_X0;
      s1_d.py       = i_pix_y - FIELD_Y0;
      s1_d.in_field = (i_pix_x >= FIELD_X0) && (s1_d.px < FIELD_W) &&
                      (i_pix_y >= FIELD_Y0) && (s1_d.py < FIELD_H);
    end
  end

  assign o_board_addr = s1_q.in_field
                      ? (10'(s1_q.py[9:3]) * FIELD_COLS + 10'(s1_q.px[9:3]))
                      : '0;

  // Shadow registers load on the same edge that captures a coincident pixel
  // into stage 1, so that pixel is tested against the new sprite positions.
  for (genvar k = 0; k < NUM_CHARS; k++) begin : g_hit
    sprite_hit_unit u_hit (
      .i_px  (s1_q.px),
      .i_py  (s1_q.py),
      .i_x   (shx_q[8*k +: 8]),
      .i_y   (shy_q[9*k +: 9]),
      .i_en  (shen_q[k]),
      .o_hit (hit[k]),
      .o_dx  (hit_dx[k]),
      .o_dy  (hit_dy[k])
    );
  end

  // Scan from clyde down to pacman so the lowest index wins.
  always_comb begin
    any_hit = 1'b0;
    win_id  = CHAR_PACMAN;
    win_dx  = '0;
    win_dy  = '0;
    for (int k = NUM_CHARS - 1; k >= 0; k--) begin
      if (hit[k]) begin
        any_hit = 1'b1;
        win_id  = char_id_e'(4'(k));
        win_dx  = hit_dx[k];
        win_dy  = hit_dy[k];
      end
    end
  end

  always_comb begin
    s2_d          = '0;
    s2_d.valid    = s1_q.valid;
    s2_d.in_field = s1_q.in_field;
    s2_d.hit      = any_hit;
    s2_d.which    = win_id;
    s2_d.dx       = win_dx;
    s2_d.dy       = win_dy;
    s2_d.tx       = s1_q.px[2:0];
    s2_d.ty       = s1_q.py[2:0];

    out_d       = '0;
    out_d.sel   = SEL_BLANK;
    out_d.valid = s2_q.valid;
    if (s2_q.valid && s2_q.in_field) begin
      if (s2_q.hit) begin
        out_d.sel   = SEL_CHAR;
        out_d.which = s2_q.which;
        out_d.coff  = {s2_q.dy, s2_q.dx};
      end else begin
        out_d.sel  = SEL_TILE;
        out_d.map  = i_board_tile;
        out_d.item = i_board_item;
        out_d.toff = {s2_q.ty, s2_q.tx};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shx_q  <= '0;
      shy_q  <= '0;
      shen_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      out_q  <= '0;
    end else begin
      shx_q  <= shx_d;
      shy_q  <= shy_d;
      shen_q <= shen_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      out_q  <= out_d;
    end
  end

  assign o_valid        = out_q.valid;
  assign o_mem_select   = out_q.sel;
  assign o_address_map  = out_q.map;
  assign o_address_item = out_q.item;
  assign o_which_char   = out_q.which;
  assign o_tile_offset  = out_q.toff;
  assign o_char_offset  = out_q.coff;

endmodule

// File: tb/tb_render_fetch_scheduler.sv
// Scoreboard bench for render_fetch_scheduler: stimulus pushes expectations,
// a negedge monitor pops and compares board address and pipeline outputs.
module tb_render_fetch_scheduler;
  import render_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_pix_valid;
  logic [9:0]  i_pix_x, i_pix_y;
  logic        i_frame_start;
  logic [39:0] i_char_x;
  logic [44:0] i_char_y;
  logic [4:0]  i_char_en;
  logic [9:0]  o_board_addr;
  logic [7:0]  i_board_tile = '0;
  logic [1:0]  i_board_item = '0;
  logic        o_valid;
  logic [1:0]  o_mem_select;
  logic [7:0]  o_address_map;
  logic [1:0]  o_address_item;
  logic [3:0]  o_which_char;
  logic [5:0]  o_tile_offset;
  logic [7:0]  o_char_offset;

  render_fetch_scheduler dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pix_valid    (i_pix_valid),
    .i_pix_x        (i_pix_x),
    .i_pix_y        (i_pix_y),
    .i_frame_start  (i_frame_start),
    .i_char_x       (i_char_x),
    .i_char_y       (i_char_y),
    .i_char_en      (i_char_en),
    .o_board_addr   (o_board_addr),
    .i_board_tile   (i_board_tile),
    .i_board_item   (i_board_item),
    .o_valid        (o_valid),
    .o_mem_select   (o_mem_select),
    .o_address_map  (o_address_map),
    .o_address_item (o_address_item),
    .o_which_char   (o_which_char),
    .o_tile_offset  (o_tile_offset),
    .o_char_offset  (o_char_offset)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [7:0] map;
    logic [1:0] item;
    logic [3:0] which;
    logic [5:0] toff;
    logic [7:0] coff;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] addr_q[$];
  exp_t       mon_e;
  logic [9:0] mon_a;
  logic       pv1;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [7:0] ram_tile(logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [1:0] ram_item(logic [9:0] a);
    return a[1:0];
  endfunction

  // Board RAM model: one-cycle read latency.
  always @(posedge clk) begin
    i_board_tile <= ram_tile(o_board_addr);
    i_board_item <= ram_item(o_board_addr);
  end

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv1 <= 1'b0;
    else        pv1 <= i_pix_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: address one cycle after a pixel, full output when o_valid.
  always @(negedge clk) begin
    if (pv1) begin
      if (addr_q.size() == 0) check("addr_unexpected", 1, 0);
      else begin
        mon_a = addr_q.pop_front();
        check("board_addr", 32'(o_board_addr), 32'(mon_a));
      end
    end
    if (o_valid) begin
      if (exp_q.size() == 0) check("valid_unexpected", 32'(o_valid), 0);
      else begin
        mon_e = exp_q.pop_front();
        check("latency_cycle", cyc, mon_e.cyc);
        check("mem_select", 32'(o_mem_select), 32'(mon_e.sel));
        check("address_map", 32'(o_address_map), 32'(mon_e.map));
        check("address_item", 32'(o_address_item), 32'(mon_e.item));
        check("which_char", 32'(o_which_char), 32'(mon_e.which));
        check("tile_offset", 32'(o_tile_offset), 32'(mon_e.toff));
        check("char_offset", 32'(o_char_offset), 32'(mon_e.coff));
      end
    end else begin
      check("idle_outputs_zero",
            32'({o_mem_select, o_address_map, o_address_item, o_which_char,
                 o_tile_offset, o_char_offset}), 0);
    end
  end

  task automatic set_char(input int k, input logic [7:0] x, input logic [8:0] y, input logic en);
    i_char_x[8*k +: 8] = x;
    i_char_y[9*k +: 9] = y;
    i_char_en[k]       = en;
  endtask

  task automatic clear_chars();
    i_char_x  = '0;
    i_char_y  = '0;
    i_char_en = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one pixel at the current negedge and record what must come back.
  task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, input logic [9:0] addr,
                           input logic [1:0] sel, input logic [3:0] which,
                           input logic [5:0] toff, input logic [7:0] coff, input logic fs);
    exp_t e;
    i_pix_valid   = 1'b1;
    i_pix_x       = x;
    i_pix_y       = y;
    i_frame_start = fs;
    e.cyc   = cyc + 3;
    e.sel   = sel;
    e.map   = (sel == SEL_TILE) ? ram_tile(addr) : 8'h00;
    e.item  = (sel == SEL_TILE) ? ram_item(addr) : 2'b00;
    e.which = which;
    e.toff  = toff;
    e.coff  = coff;
    exp_q.push_back(e);
    addr_q.push_back(addr);
  endtask

  task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [9:0] addr,
                      input logic [1:0] sel, input logic [3:0] which,
                      input logic [5:0] toff, input logic [7:0] coff, input logic fs);
    drive_pix(x, y, addr, sel, which, toff, coff, fs);
    @(negedge clk);
    i_pix_valid   = 1'b0;
    i_frame_start = 1'b0;
  endtask

  task automatic load_frame();
    i_frame_start = 1'b1;
    @(negedge clk);
    i_frame_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    i_pix_valid   = 1'b0;
    i_pix_x       = '0;
    i_pix_y       = '0;
    i_frame_start = 1'b0;
    clear_chars();

    repeat (3) @(negedge clk);
    check("reset_valid", 32'(o_valid), 0);
    check("reset_addr", 32'(o_board_addr), 0);
    check("reset_data", 32'({o_mem_select, o_address_map, o_address_item,
                             o_which_char, o_tile_offset, o_char_offset}), 0);
    rst_n = 1'b1;
    idle(3);

    // Tile path and field boundaries, no sprites enabled.
    send(10'd208, 10'd96,  10'd0,    SEL_TILE,  4'd0, 6'd0,  8'd0, 1'b0);
    send(10'd219, 10'd109, 10'd29,   SEL_TILE,  4'd0, 6'd43, 8'd0, 1'b0);
    send(10'd431, 10'd383, 10'd1007, SEL_TILE,  4'd0, 6'd63, 8'd0, 1'b0);
    send(10'd432, 10'd96,  10'd0,    SEL_BLANK, 4'd0, 6'd0,  8'd0, 1'b0);
    send(10'd207, 10'd96,  10'd0,    SEL_BLANK, 4'd0, 6'd0,  8'd0, 1'b0);
    send(10'd208, 10'd384, 10'd0,    SEL_BLANK, 4'd0, 6'd0,  8'd0, 1'b0);
    send(10'd100, 10'd100, 10'd0,    SEL_BLANK, 4'd0, 6'd0,  8'd0, 1'b0);
    idle(4);

    // Pacman at (8,8); pixel px=15 py=20 -> dy*16+dx = 12*16+7 = 199.
    set_char(0, 8'd8, 9'd8, 1'b1);
    load_frame();
    send(10'd223, 10'd116, 10'd57, SEL_CHAR, 4'd0, 6'd0, 8'd199, 1'b0);
    set_char(1, 8'd8, 9'd8, 1'b1);
    load_frame();
    send(10'd223, 10'd116, 10'd57, SEL_CHAR, 4'd0, 6'd0, 8'd199, 1'b0);
    idle(4);

    // Clyde enabled on the same cycle as the pixel: (45-40)+(53-50)*16 = 53.
    clear_chars();
    set_char(4, 8'd40, 9'd50, 1'b1);
    send(10'd253, 10'd149, 10'd173, SEL_CHAR, 4'd4, 6'd0, 8'd53, 1'b1);
    idle(4);

    // Pacman straddling the right tunnel edge.
    clear_chars();
    set_char(0, 8'd220, 9'd0, 1'b1);
    load_frame();
`ifdef RENDER_TUNNEL_WRAP_EN
    send(10'd210, 10'd96, 10'd0, SEL_CHAR, 4'd0, 6'd0, 8'd6, 1'b0);
`else
    send(10'd210, 10'd96, 10'd0, SEL_TILE, 4'd0, 6'd2, 8'd0, 1'b0);
`endif
    send(10'd431, 10'd96, 10'd27, SEL_CHAR,  4'd0, 6'd0, 8'd3, 1'b0);
    send(10'd432, 10'd96, 10'd0,  SEL_BLANK, 4'd0, 6'd0, 8'd0, 1'b0);
    idle(5);

    // Reset with all three stages occupied.
    drive_pix(10'd208, 10'd96, 10'd0, SEL_TILE, 4'd0, 6'd0, 8'd0, 1'b0);
    @(negedge clk);
    drive_pix(10'd216, 10'd96, 10'd1, SEL_TILE, 4'd0, 6'd0, 8'd0, 1'b0);
    @(negedge clk);
    drive_pix(10'd224, 10'd96, 10'd2, SEL_TILE, 4'd0, 6'd0, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    check("inflight_valid", 32'(o_valid), 1);
    rst_n       = 1'b0;
    i_pix_valid = 1'b0;
    #1;
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_addr", 32'(o_board_addr), 0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    check("leftover_outputs", exp_q.size(), 0);
    check("leftover_addrs", addr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/render_fetch_scheduler.md
Name: render_fetch_scheduler

Overview:
- Pixel-to-memory-address front end that sits directly upstream of the tile/sprite memory controller.
- For every visible VGA pixel it resolves whether the pixel lies outside the playfield, on a maze tile, or inside a character sprite.
- It fetches the board tile/item for that pixel from the board RAM.
- It drives the controller's select, map, item, char and offset inputs through a fixed-latency pipeline.

Parameters:
- FIELD_X0, 208: screen x of playfield left edge.
- FIELD_Y0, 96: screen y of playfield top edge.
- FIELD_COLS, 28: playfield width in 8x8 tiles (224 px).
- FIELD_ROWS, 36: playfield height in tiles (288 px).
- SPRITE_SIZE, 16: sprite box edge in pixels; fixed at 16.

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pix_valid  in  1  i_pix_x/i_pix_y describe an active pixel this cycle
- i_pix_x  in  10  screen column
- i_pix_y  in  10  screen row
- i_frame_start  in  1  one-cycle pulse in vertical blanking; latches sprite state
- i_char_x  in  40  5x8 packed sprite top-left x in playfield px; [7:0]=pacman, then blinky, pinky, inky, clyde
- i_char_y  in  45  5x9 packed sprite top-left y, same order
- i_char_en  in  5  per-character visible flag, same order
- o_board_addr  out  10  board RAM address, row*28+col
- i_board_tile  in  8  board RAM tile index, valid one cycle after o_board_addr
- i_board_item  in  2  board RAM item code, same timing
- o_valid  out  1  outputs below describe a pixel
- o_mem_select  out  2  00 blank, 01 tile, 11 char
- o_address_map  out  8  tile index
- o_address_item  out  2  item code
- o_which_char  out  4  0 pacman .. 4 clyde
- o_tile_offset  out  6  ty[2:0]*8+tx[2:0]
- o_char_offset  out  8  dy*16+dx

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0, o_valid 0, shadow sprite registers 0, shadow enables 0, all pipeline valids 0.
- Reset asserted mid-operation flushes every stage; no partial pixel is emitted after release.
- Pipeline is 3 stages and never stalls. A pixel presented in cycle N emerges with o_valid=1 in cycle N+3.
- Stage 1 registers:
  - px=pix_x-FIELD_X0 and py=pix_y-FIELD_Y0, each 10-bit.
  - in_field = (pix_x>=FIELD_X0) && (px<224) && (pix_y>=FIELD_Y0) && (py<288).
  - o_board_addr = (py>>3)*28 + (px>>3), driven from stage-1 registers; 0 when !in_field.
- Stage 1 sprite hit test: for each character k with shadow enable set, hit_k = (px-x_k) in [0,15] and (py-y_k) in [0,15], using unsigned compare on width-extended differences.
- Priority is fixed: pacman > blinky > pinky > inky > clyde. The winner's dx/dy are carried forward.
- Stage 2: carries the hit result, winner, dx, dy, px[2:0], py[2:0] and in_field. i_board_tile and i_board_item are sampled at the end of stage 2.
- Stage 3 output register:
  - !in_field: mem_select=00, all other outputs 0.
  - in_field with any hit: mem_select=11, which_char=winner, char_offset=dy*16+dx, tile/map/item=0.
  - otherwise: mem_select=01, address_map=tile, address_item=item, tile_offset=py[2:0]*8+px[2:0], which_char=0, char_offset=0.
- Invalid pixel: o_valid=0 and all data outputs forced to 0.
- Shadow sprite registers load i_char_x, i_char_y and i_char_en on the edge closing a cycle with i_frame_start=1.
- Coincident i_frame_start and i_pix_valid: that pixel is hit-tested against the newly loaded values.
- Sprites extending past x=223 or y=287 are clipped by the in_field test.

Optional Feature:
- Macro: RENDER_TUNNEL_WRAP_EN.
- Defined: horizontal hit distance is computed modulo 224, dx=(px-x_k+224)%224. A sprite straddling the tunnel edge shows on both sides.
- Undefined: plain difference; the portion beyond x=223 is not drawn.

Decomposition:
- Shared package render_pkg: mem_select encodings (SEL_BLANK, SEL_TILE, SEL_CHAR), char IDs (CHAR_PACMAN..CHAR_CLYDE), NUM_CHARS=5, field dimension constants.
- Item codes stay in the existing params header.
- Sub-module sprite_hit_unit: combinational per-character box test returning hit, dx, dy. Instantiated 5 times plus a priority encoder.

Test Plan:
- Pixel (208,96) valid at cycle 10 -> o_board_addr=0 at cycle 11; o_valid=1 at cycle 13, mem_select=01, tile_offset=0, map=i_board_tile returned.
- Pixel (219,109), no sprites -> board_addr=29, tile_offset=43, item passed through.
- Pacman at (8,8) enabled, pixel at px=15, py=20 -> mem_select=11, which_char=0, char_offset=199. Add blinky at the same spot -> still which_char=0.
- Pixel (100,100) -> mem_select=00, all other outputs 0, o_valid=1 at N+3.
- i_frame_start coincident with a pixel over a newly enabled clyde -> which_char=4. Assert i_rst_n low with 3 pixels in flight -> o_valid=0 immediately and no output afterwards.
- Pacman x=220, y=0, pixel px=2, py=0: with RENDER_TUNNEL_WRAP_EN -> char_offset=6, mem_select=11; without -> mem_select=01.
